// File: rtl/mean_filter_mc_if.sv
// mean_filter_mc_if: video-stream bundle into and out of the mean filter.
// The source drives the din side; the filter drives the dout side.
interface mean_filter_mc_if #(
  parameter int DW = 8,
  parameter int CH = 1
);
  logic             mf_din_vsync;
  logic             mf_din_hsync;
  logic [CH*DW-1:0] mf_din;
  logic             mf_bypass;
  logic             mf_dout_vsync;
  logic             mf_dout_hsync;
  logic [CH*DW-1:0] mf_dout;
  logic             mf_dout_win;

  modport master (
    output mf_din_vsync,
    output mf_din_hsync,
    output mf_din,
    output mf_bypass,
    input  mf_dout_vsync,
    input  mf_dout_hsync,
    input  mf_dout,
    input  mf_dout_win
  );

  modport slave (
    input  mf_din_vsync,
    input  mf_din_hsync,
    input  mf_din,
    input  mf_bypass,
    output mf_dout_vsync,
    output mf_dout_hsync,
    output mf_dout,
    output mf_dout_win
  );
endinterface

// File: rtl/mean_filter_mc.sv
// mean_filter_mc: KSZxKSZ box filter with internal line buffers.
// Four register stages: window, sum, mean, output.
module mean_filter_mc #(
  parameter int KSZ  = 3,
  parameter int DW   = 8,
  parameter int CH   = 1,
  parameter int IW   = 640,
  parameter int IH   = 480,
  parameter int FILL = 1
) (
  input logic             clk,
  input logic             rst_n,
  mean_filter_mc_if.slave mf
);
  localparam int PW = CH * DW;
  localparam int SW = DW + 6;
  localparam int XW = $clog2(IW + 1);
  localparam int AW = (IW > 1) ? $clog2(IW) : 1;
  localparam int NB = KSZ - 1;
  localparam logic [SW-1:0] K2   = SW'(KSZ * KSZ);
  localparam logic [SW-1:0] HALF = SW'((KSZ * KSZ) / 2);
  localparam bit CFG_OK = (KSZ == 3 || KSZ == 5 || KSZ == 7)
                       && CH >= 1 && CH <= 4 && IH >= 1;

  typedef enum logic {UNSYNC, RUN} state_t;

  state_t        state_q, state_d;
  logic          byp_q, byp_d;
  logic          vs_prev_q, vs_prev_d;
  logic          hs_prev_q, hs_prev_d;
  logic [XW-1:0] x_q, x_d;
  logic [15:0]   y_q, y_d;

  logic [PW-1:0] win_q [KSZ][KSZ];
  logic [PW-1:0] win_d [KSZ][KSZ];
  logic [PW-1:0] lb_mem [NB][IW];
  logic [PW-1:0] col [KSZ];

  logic          hs1_q, hs1_d, vs1_q, vs1_d;
  logic          full1_q, full1_d, pass1_q, pass1_d;
  logic [PW-1:0] raw1_q, raw1_d;
  logic          hs2_q, hs2_d, vs2_q, vs2_d;
  logic          full2_q, full2_d, pass2_q, pass2_d;
  logic [PW-1:0] raw2_q, raw2_d;
  logic [SW-1:0] sum2_q [CH];
  logic [SW-1:0] sum2_d [CH];
  logic          hs3_q, hs3_d, vs3_q, vs3_d;
  logic          full3_q, full3_d, pass3_q, pass3_d;
  logic [PW-1:0] raw3_q, raw3_d;
  logic [PW-1:0] mean3_q, mean3_d;
  logic          hs4_q, hs4_d, vs4_q, vs4_d;
  logic          win4_q, win4_d;
  logic [PW-1:0] dout4_q, dout4_d;

  logic          pix, vs_rise, hs_fall, in_row, wr_en;
  logic          full0, pass0;
  logic [AW-1:0] addr;

  always_comb begin
    pix     = mf.mf_din_hsync;
    vs_rise = mf.mf_din_vsync & ~vs_prev_q;
    hs_fall = ~mf.mf_din_hsync & hs_prev_q;
    in_row  = x_q < XW'(IW);
    wr_en   = pix & in_row;
    addr    = x_q[AW-1:0];

    vs_prev_d = mf.mf_din_vsync;
    hs_prev_d = mf.mf_din_hsync;
    state_d   = state_q;
    byp_d     = byp_q;
    if (vs_rise) begin
      state_d = RUN;
      byp_d   = mf.mf_bypass;
    end

    x_d = x_q;
    if (hs_fall) x_d = '0;
    else if (pix && in_row) x_d = x_q + XW'(1);
    y_d = y_q;
    if (vs_rise) y_d = '0;
    else if (hs_fall && y_q != 16'hFFFF) y_d = y_q + 16'd1;

    // Row KSZ-1 is the live line; older rows come out of the buffer chain.
    col[KSZ-1] = mf.mf_din;
    for (int j = 0; j < NB; j++) col[KSZ-2-j] = lb_mem[j][addr];

    win_d = win_q;
    if (pix) begin
      for (int r = 0; r < KSZ; r++) begin
        for (int c = 0; c < KSZ - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][KSZ-1] = col[r];
      end
    end

    full0 = CFG_OK && state_q == RUN && !byp_q && in_row
         && x_q >= XW'(KSZ - 1) && y_q >= 16'(KSZ - 1);
    pass0 = state_q == UNSYNC || byp_q;

    hs1_d = pix; vs1_d = mf.mf_din_vsync;
    full1_d = full0; pass1_d = pass0; raw1_d = mf.mf_din;

    hs2_d = hs1_q; vs2_d = vs1_q;
    full2_d = full1_q; pass2_d = pass1_q; raw2_d = raw1_q;
    for (int ch = 0; ch < CH; ch++) begin
      sum2_d[ch] = '0;
      for (int r = 0; r < KSZ; r++)
        for (int c = 0; c < KSZ; c++)
          sum2_d[ch] = sum2_d[ch] + SW'(win_q[r][c][ch*DW +: DW]);
    end

    hs3_d = hs2_q; vs3_d = vs2_q;
    full3_d = full2_q; pass3_d = pass2_q; raw3_d = raw2_q;
    mean3_d = '0;
    for (int ch = 0; ch < CH; ch++)
      mean3_d[ch*DW +: DW] = DW'((sum2_q[ch] + HALF) / K2);

    hs4_d = hs3_q; vs4_d = vs3_q;
    win4_d = 1'b0; dout4_d = '0;
    if (hs3_q) begin
      if (pass3_q) dout4_d = raw3_q;
      else if (full3_q) begin
        dout4_d = mean3_q;
        win4_d  = 1'b1;
      end else if (FILL != 0) dout4_d = raw3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb_mem[0][addr] <= mf.mf_din;
      for (int j = 1; j < NB; j++) lb_mem[j][addr] <= lb_mem[j-1][addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNSYNC;
      byp_q <= 1'b0;
      // A vsync already high at reset release is not a frame start.
      vs_prev_q <= 1'b1;
      hs_prev_q <= 1'b0;
      x_q <= '0; y_q <= '0;
      for (int r = 0; r < KSZ; r++)
        for (int c = 0; c < KSZ; c++) win_q[r][c] <= '0;
      hs1_q <= 1'b0; vs1_q <= 1'b0; full1_q <= 1'b0;
      pass1_q <= 1'b0; raw1_q <= '0;
      hs2_q <= 1'b0; vs2_q <= 1'b0; full2_q <= 1'b0;
      pass2_q <= 1'b0; raw2_q <= '0;
      for (int ch = 0; ch < CH; ch++) sum2_q[ch] <= '0;
      hs3_q <= 1'b0; vs3_q <= 1'b0; full3_q <= 1'b0;
      pass3_q <= 1'b0; raw3_q <= '0; mean3_q <= '0;
      hs4_q <= 1'b0; vs4_q <= 1'b0; win4_q <= 1'b0; dout4_q <= '0;
    end else begin
      state_q <= state_d;
      byp_q <= byp_d;
      vs_prev_q <= vs_prev_d;
      hs_prev_q <= hs_prev_d;
      x_q <= x_d; y_q <= y_d;
      win_q <= win_d;
      hs1_q <= hs1_d; vs1_q <= vs1_d; full1_q <= full1_d;
      pass1_q <= pass1_d; raw1_q <= raw1_d;
      hs2_q <= hs2_d; vs2_q <= vs2_d; full2_q <= full2_d;
      pass2_q <= pass2_d; raw2_q <= raw2_d;
      sum2_q <= sum2_d;
      hs3_q <= hs3_d; vs3_q <= vs3_d; full3_q <= full3_d;
      pass3_q <= pass3_d; raw3_q <= raw3_d; mean3_q <= mean3_d;
      hs4_q <= hs4_d; vs4_q <= vs4_d; win4_q <= win4_d; dout4_q <= dout4_d;
    end
  end

  assign mf.mf_dout_vsync = vs4_q;
  assign mf.mf_dout_hsync = hs4_q;
  assign mf.mf_dout       = dout4_q;
  assign mf.mf_dout_win   = win4_q;
endmodule

// File: tb/tb_mean_filter_mc.sv
// tb_mean_filter_mc: directed frames into three filter configurations.
// Outputs are captured per cycle and checked against hand-derived values.
module tb_mean_filter_mc;
  localparam int NC = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs, hs, byp;
  logic [23:0] din;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          rst_k = 0;

  logic [23:0] img [16][16];
  int          pk [16][16];

  logic        in_hs [NC];
  logic        in_vs [NC];
  logic        a_hs [NC];
  logic        a_vs [NC];
  logic        a_win [NC];
  logic [7:0]  a_do [NC];
  logic        b_win [NC];
  logic [7:0]  b_do [NC];
  logic        c_win [NC];
  logic [23:0] c_do [NC];

  mean_filter_mc_if #(.DW(8), .CH(1)) ifa ();
  mean_filter_mc_if #(.DW(8), .CH(1)) ifb ();
  mean_filter_mc_if #(.DW(8), .CH(3)) ifc ();

  assign ifa.mf_din_vsync = vs;
  assign ifa.mf_din_hsync = hs;
  assign ifa.mf_din       = din[7:0];
  assign ifa.mf_bypass    = byp;
  assign ifb.mf_din_vsync = vs;
  assign ifb.mf_din_hsync = hs;
  assign ifb.mf_din       = din[7:0];
  assign ifb.mf_bypass    = byp;
  assign ifc.mf_din_vsync = vs;
  assign ifc.mf_din_hsync = hs;
  assign ifc.mf_din       = din;
  assign ifc.mf_bypass    = byp;

  mean_filter_mc #(.KSZ(3), .DW(8), .CH(1), .IW(8), .IH(6), .FILL(1))
    u_a (.clk(clk), .rst_n(rst_n), .mf(ifa));
  mean_filter_mc #(.KSZ(3), .DW(8), .CH(1), .IW(8), .IH(6), .FILL(0))
    u_b (.clk(clk), .rst_n(rst_n), .mf(ifb));
  mean_filter_mc #(.KSZ(7), .DW(8), .CH(3), .IW(16), .IH(8), .FILL(1))
    u_c (.clk(clk), .rst_n(rst_n), .mf(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < NC) begin
      in_hs[cyc] <= hs;
      in_vs[cyc] <= vs;
      a_hs[cyc]  <= ifa.mf_dout_hsync;
      a_vs[cyc]  <= ifa.mf_dout_vsync;
      a_win[cyc] <= ifa.mf_dout_win;
      a_do[cyc]  <= ifa.mf_dout;
      b_win[cyc] <= ifb.mf_dout_win;
      b_do[cyc]  <= ifb.mf_dout;
      c_win[cyc] <= ifc.mf_dout_win;
      c_do[cyc]  <= ifc.mf_dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ev_kind: 0 none, 1 raise bypass, 2 lower bypass, 3 reset pulse
  task automatic drive_frame(input int lines, input int len,
                             input int ev_line, input int ev_kind);
    vs = 1'b1;
    tick();
    tick();
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < len; x++) begin
        if (y == ev_line && x == 0 && ev_kind == 1) byp = 1'b1;
        if (y == ev_line && x == 0 && ev_kind == 2) byp = 1'b0;
        if (y == ev_line && x == 2 && ev_kind == 3) begin
          rst_n = 1'b0;
          rst_k = cyc;
        end
        if (y == ev_line && x == 5 && ev_kind == 3) rst_n = 1'b1;
        hs = 1'b1;
        din = img[y][x];
        pk[y][x] = cyc;
        tick();
      end
      hs = 1'b0;
      din = '0;
      repeat (3) tick();
    end
    repeat (2) tick();
    vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic set_const(input logic [23:0] v);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) img[y][x] = v;
  endtask

  task automatic set_ramp();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) img[y][x] = 24'(x + 8 * y);
  endtask

  task automatic test_reset();
    vs = 1'b0; hs = 1'b0; din = '0; byp = 1'b0; rst_n = 1'b0;
    repeat (4) tick();
    nvec++;
    if ({ifa.mf_dout_hsync, ifa.mf_dout_vsync, ifa.mf_dout_win, ifa.mf_dout} !== 11'd0) begin
      nerr++;
      $display("FAIL reset_a got %b want 0", {ifa.mf_dout_hsync, ifa.mf_dout_vsync, ifa.mf_dout_win, ifa.mf_dout});
    end
    nvec++;
    if ({ifb.mf_dout_hsync, ifb.mf_dout_win, ifb.mf_dout} !== 10'd0) begin
      nerr++;
      $display("FAIL reset_b got %b want 0", {ifb.mf_dout_hsync, ifb.mf_dout_win, ifb.mf_dout});
    end
    nvec++;
    if ({ifc.mf_dout_hsync, ifc.mf_dout_win, ifc.mf_dout} !== 26'd0) begin
      nerr++;
      $display("FAIL reset_c got %h want 0", {ifc.mf_dout_hsync, ifc.mf_dout_win, ifc.mf_dout});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    nvec++;
    if ({ifa.mf_dout_hsync, ifa.mf_dout} !== 9'd0) begin
      nerr++;
      $display("FAIL idle_a got %b want 0", {ifa.mf_dout_hsync, ifa.mf_dout});
    end
  endtask

  task automatic test_const();
    int n = 0;
    set_const(24'd100);
    drive_frame(6, 8, -1, 0);
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        int k = pk[y][x] + 4;
        logic ew = (x >= 2 && y >= 2);
        if (a_win[k] === 1'b1) n++;
        nvec++;
        if (a_do[k] !== 8'd100) begin
          nerr++;
          $display("FAIL const_a_dout y=%0d x=%0d got %0d want 100", y, x, a_do[k]);
        end
        nvec++;
        if (a_win[k] !== ew) begin
          nerr++;
          $display("FAIL const_a_win y=%0d x=%0d got %b want %b", y, x, a_win[k], ew);
        end
        nvec++;
        if (b_do[k] !== (ew ? 8'd100 : 8'd0) || b_win[k] !== ew) begin
          nerr++;
          $display("FAIL fill0_b y=%0d x=%0d got %0d/%b want %0d/%b", y, x, b_do[k], b_win[k], ew ? 100 : 0, ew);
        end
      end
    end
    nvec++;
    if (n !== 24) begin
      nerr++;
      $display("FAIL const_win_count got %0d want 24", n);
    end
    for (int i = pk[0][0] - 3; i <= pk[5][7] + 6; i++) begin
      nvec++;
      if ({a_hs[i+4], a_vs[i+4]} !== {in_hs[i], in_vs[i]}) begin
        nerr++;
        $display("FAIL sync_delay i=%0d got %b%b want %b%b", i, a_hs[i+4], a_vs[i+4], in_hs[i], in_vs[i]);
      end
      if (in_hs[i] === 1'b0) begin
        nvec++;
        if ({a_win[i+4], a_do[i+4]} !== 9'd0) begin
          nerr++;
          $display("FAIL blank_zero i=%0d got %0d want 0", i, a_do[i+4]);
        end
      end
    end
  endtask

  task automatic test_ramp();
    set_ramp();
    drive_frame(6, 8, -1, 0);
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        int k = pk[y][x] + 4;
        int e = (x >= 2 && y >= 2) ? (x - 1) + 8 * (y - 1) : x + 8 * y;
        nvec++;
        if (a_do[k] !== 8'(e)) begin
          nerr++;
          $display("FAIL ramp y=%0d x=%0d got %0d want %0d", y, x, a_do[k], e);
        end
      end
    end
    nvec++;
    if (a_do[pk[5][7]+4] !== 8'd38) begin
      nerr++;
      $display("FAIL ramp_5_7 got %0d want 38", a_do[pk[5][7]+4]);
    end
  endtask

  task automatic test_impulse();
    for (int v = 4; v <= 5; v++) begin
      set_const(24'd0);
      img[3][3] = 24'(v);
      drive_frame(6, 8, -1, 0);
      for (int y = 2; y < 6; y++) begin
        for (int x = 2; x < 8; x++) begin
          int k = pk[y][x] + 4;
          int hit = (x >= 3 && x <= 5 && y >= 3 && y <= 5) ? 1 : 0;
          int e = (v == 5) ? hit : 0;
          nvec++;
          if (a_do[k] !== 8'(e) || a_win[k] !== 1'b1) begin
            nerr++;
            $display("FAIL impulse%0d y=%0d x=%0d got %0d/%b want %0d/1", v, y, x, a_do[k], a_win[k], e);
          end
        end
      end
    end
  endtask

  task automatic test_multich();
    int n = 0;
    set_const(24'hFFC80A);
    drive_frame(8, 16, -1, 0);
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        int k = pk[y][x] + 4;
        logic ew = (x >= 6 && y >= 6);
        logic aw = (x >= 2 && x < 8 && y >= 2);
        if (c_win[k] === 1'b1) n++;
        nvec++;
        if (c_do[k] !== 24'hFFC80A || c_win[k] !== ew) begin
          nerr++;
          $display("FAIL multich y=%0d x=%0d got %h/%b want ffc80a/%b", y, x, c_do[k], c_win[k], ew);
        end
        nvec++;
        if (a_do[k] !== 8'h0A || a_win[k] !== aw) begin
          nerr++;
          $display("FAIL longline_a y=%0d x=%0d got %0d/%b want 10/%b", y, x, a_do[k], a_win[k], aw);
        end
        nvec++;
        if (b_do[k] !== (aw ? 8'h0A : 8'h00)) begin
          nerr++;
          $display("FAIL longline_b y=%0d x=%0d got %0d want %0d", y, x, b_do[k], aw ? 10 : 0);
        end
      end
    end
    nvec++;
    if (n !== 20) begin
      nerr++;
      $display("FAIL multich_win_count got %0d want 20", n);
    end
  endtask

  task automatic test_bypass();
    int n = 0;
    set_ramp();
    drive_frame(6, 8, 3, 1);
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++)
        if (a_win[pk[y][x]+4] === 1'b1) n++;
    nvec++;
    if (n !== 24 || a_do[pk[5][7]+4] !== 8'd38) begin
      nerr++;
      $display("FAIL byp_frame_n got %0d/%0d want 24/38", n, a_do[pk[5][7]+4]);
    end
    drive_frame(6, 8, 3, 2);
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        int k = pk[y][x] + 4;
        nvec++;
        if (a_do[k] !== img[y][x][7:0] || a_win[k] !== 1'b0) begin
          nerr++;
          $display("FAIL byp_raw y=%0d x=%0d got %0d/%b want %0d/0", y, x, a_do[k], a_win[k], img[y][x][7:0]);
        end
      end
    end
    drive_frame(6, 8, -1, 0);
    n = 0;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++)
        if (a_win[pk[y][x]+4] === 1'b1) n++;
    nvec++;
    if (n !== 24 || a_do[pk[5][7]+4] !== 8'd38 || a_do[pk[2][2]+4] !== 8'd9) begin
      nerr++;
      $display("FAIL byp_restore got %0d/%0d/%0d want 24/38/9", n, a_do[pk[5][7]+4], a_do[pk[2][2]+4]);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    set_ramp();
    drive_frame(6, 8, 3, 3);
    for (int i = rst_k + 1; i <= rst_k + 3; i++) begin
      nvec++;
      if ({a_hs[i], a_vs[i], a_win[i], a_do[i]} !== 11'd0) begin
        nerr++;
        $display("FAIL in_reset i=%0d got %b want 0", i, {a_hs[i], a_vs[i], a_win[i], a_do[i]});
      end
    end
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        int k = pk[y][x] + 4;
        if (pk[y][x] >= rst_k + 3) begin
          nvec++;
          if (a_do[k] !== img[y][x][7:0] || a_win[k] !== 1'b0) begin
            nerr++;
            $display("FAIL unsync_raw y=%0d x=%0d got %0d/%b want %0d/0", y, x, a_do[k], a_win[k], img[y][x][7:0]);
          end
        end
      end
    end
    drive_frame(6, 8, -1, 0);
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++)
        if (a_win[pk[y][x]+4] === 1'b1) n++;
    nvec++;
    if (n !== 24 || a_win[pk[2][2]+4] !== 1'b1 || a_do[pk[2][2]+4] !== 8'd9) begin
      nerr++;
      $display("FAIL resync got %0d/%b/%0d want 24/1/9", n, a_win[pk[2][2]+4], a_do[pk[2][2]+4]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vs = 1'b0;
    hs = 1'b0;
    din = '0;
    byp = 1'b0;
    test_reset();
    test_const();
    test_ramp();
    test_impulse();
    test_multich();
    test_bypass();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
